// File: rtl/alu_result_stage.sv
// ALU result stage: captures ALU results, resolves branch-taken, and holds them in a 2-entry skid buffer.
// Optional build macro RESULT_STAGE_X0_GUARD_EN: entries with in_rd == 0 are stored with we = 0.
module alu_result_stage #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned RD_BITS      = 5,
    parameter int unsigned ERR_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_ans,
    input  logic [2:0]              in_flag,
    input  logic                    in_error,
    input  logic [2:0]              in_br_type,
    input  logic [RD_BITS-1:0]      in_rd,
    input  logic                    in_we,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_ans,
    output logic [RD_BITS-1:0]      out_rd,
    output logic                    out_we,
    output logic                    out_br_taken,
    output logic                    out_error,
    output logic [ERR_CNT_BITS-1:0] err_cnt
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_RSVD = 3'd7
    } br_type_t;

    typedef struct packed {
        logic [WIDTH-1:0]   ans;
        logic [RD_BITS-1:0] rd;
        logic               we;
        logic               br_taken;
        logic               error;
    } entry_t;

    // slot0 is always the head; slot1 holds the second-oldest entry
    entry_t      slot0, slot1;
    logic [1:0]  occ;
    entry_t      new_entry;
    logic        br_raw;
    logic        we_raw;
    logic        push, pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        br_raw = 1'b0;
        case (br_type_t'(in_br_type))
            BR_BEQ:  br_raw = in_flag[0];
            BR_BNE:  br_raw = !in_flag[0];
            BR_BLT:  br_raw = in_flag[1];
            BR_BGE:  br_raw = !in_flag[1];
            BR_BLTU: br_raw = in_flag[2];
            BR_BGEU: br_raw = !in_flag[2];
            default: br_raw = 1'b0;
        endcase
    end

`ifdef RESULT_STAGE_X0_GUARD_EN
    assign we_raw = in_we && (in_rd != '0);
`else
    assign we_raw = in_we;
`endif

    always_comb begin
        new_entry          = '0;
        new_entry.ans      = in_ans;
        new_entry.rd       = in_rd;
        new_entry.we       = we_raw && !in_error;
        new_entry.br_taken = br_raw && !in_error;
        new_entry.error    = in_error;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        slot0 <= new_entry;
                        occ   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        slot0 <= new_entry;
                    end else if (push) begin
                        slot1 <= new_entry;
                        occ   <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        slot0 <= slot1;
                        occ   <= 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (push && in_error && !flush && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign out_ans      = slot0.ans;
    assign out_rd       = slot0.rd;
    assign out_we       = slot0.we;
    assign out_br_taken = slot0.br_taken;
    assign out_error    = slot0.error;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: vector table plus handshake, saturation, flush and reset sequences.
module tb_alu_result_stage;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ans;
    logic [2:0]  in_flag;
    logic        in_error;
    logic [2:0]  in_br_type;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ans;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_br_taken;
    logic        out_error;
    logic [7:0]  err_cnt;

    int passed;
    int total;
    int exp_errs;

    alu_result_stage #(.WIDTH(32), .RD_BITS(5), .ERR_CNT_BITS(8)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_ans(in_ans), .in_flag(in_flag),
        .in_error(in_error), .in_br_type(in_br_type), .in_rd(in_rd), .in_we(in_we),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ans(out_ans), .out_rd(out_rd),
        .out_we(out_we), .out_br_taken(out_br_taken), .out_error(out_error),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ans;
        logic [2:0]  flag;
        logic        err;
        logic [2:0]  bt;
        logic [4:0]  rd;
        logic        we;
        logic        exp_we;
        logic        exp_br;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] f, input logic e,
                         input logic [2:0] bt, input logic [4:0] rd, input logic we);
        in_valid = v; in_ans = a; in_flag = f; in_error = e; in_br_type = bt; in_rd = rd; in_we = we;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 3'b000, 1'b0, 3'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #7;
        rstn = 1'b1;
        step();
    endtask

    initial begin
        passed = 0; total = 0; exp_errs = 0;
        flush = 1'b0; out_ready = 1'b1;
        idle();

        vecs[0]  = '{32'h0000_0005, 3'b000, 1'b0, 3'd0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0011, 3'b001, 1'b0, 3'd1, 5'd1,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0022, 3'b100, 1'b0, 3'd6, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_0033, 3'b010, 1'b0, 3'd4, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0044, 3'b000, 1'b0, 3'd7, 5'd6,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0055, 3'b000, 1'b0, 3'd2, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'hDEAD_BEEF, 3'b010, 1'b0, 3'd3, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h1234_5678, 3'b100, 1'b0, 3'd5, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_0099, 3'b000, 1'b0, 3'd6, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000_0000, 3'b001, 1'b1, 3'd1, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h0000_00AA, 3'b011, 1'b0, 3'd1, 5'd0,  1'b1,
`ifdef RESULT_STAGE_X0_GUARD_EN
                     1'b0,
`else
                     1'b1,
`endif
                     1'b1, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 3'b111, 1'b1, 3'd2, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset state
        rstn = 1'b0;
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_ans", out_ans, 32'd0);
        check("rst_out_rd", {27'b0, out_rd}, 32'd0);
        check("rst_out_we", {31'b0, out_we}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        #4;
        rstn = 1'b1;
        step();

        // table: push one entry, check head, let it pop
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].ans, vecs[i].flag, vecs[i].err, vecs[i].bt, vecs[i].rd, vecs[i].we);
            step();
            idle();
            if (vecs[i].err) exp_errs++;
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d_ans", i), out_ans, vecs[i].ans);
            check($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d_we", i), {31'b0, out_we}, {31'b0, vecs[i].exp_we});
            check($sformatf("v%0d_br", i), {31'b0, out_br_taken}, {31'b0, vecs[i].exp_br});
            check($sformatf("v%0d_err", i), {31'b0, out_error}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_errcnt", i), {24'b0, err_cnt}, exp_errs);
            step();
            check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'd0);
        end

        // back-pressure and ordering
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 3'b000, 1'b0, 3'd0, 5'd1, 1'b1);
        step();
        drive(1'b1, 32'hB, 3'b000, 1'b0, 3'd0, 5'd2, 1'b1);
        step();
        check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'hC, 3'b000, 1'b0, 3'd0, 5'd3, 1'b1);
        step();
        check("bp_head_held", out_ans, 32'hA);
        check("bp_still_full", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_second", out_ans, 32'hB);
        check("bp_second_rd", {27'b0, out_rd}, 32'd2);
        step();
        idle();
        check("bp_third", out_ans, 32'hC);
        check("bp_third_valid", {31'b0, out_valid}, 32'd1);
        step();
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // saturating error counter: continuous push/pop at occupancy 1
        drive(1'b1, 32'h0, 3'b000, 1'b1, 3'd0, 5'd4, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (!in_ready) check("sat_in_ready", {31'b0, in_ready}, 32'd1);
            step();
            if (i == 250 - exp_errs) check("sat_mid", {24'b0, err_cnt}, 32'd251);
        end
        idle();
        check("sat_255", {24'b0, err_cnt}, 32'd255);
        step();

        // flush with push at occupancy 1 drops the push and its count
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 3'b000, 1'b1, 3'd0, 5'd1, 1'b1);
        step();
        check("fl_cnt_before", {24'b0, err_cnt}, 32'd1);
        flush = 1'b1;
        drive(1'b1, 32'h2, 3'b000, 1'b1, 3'd0, 5'd2, 1'b1);
        step();
        flush = 1'b0;
        idle();
        check("fl1_valid", {31'b0, out_valid}, 32'd0);
        check("fl1_ready", {31'b0, in_ready}, 32'd1);
        check("fl1_cnt", {24'b0, err_cnt}, 32'd1);

        // flush at occupancy 2 with in_valid/in_error offered
        drive(1'b1, 32'h3, 3'b000, 1'b0, 3'd0, 5'd3, 1'b1);
        step();
        drive(1'b1, 32'h4, 3'b000, 1'b0, 3'd0, 5'd4, 1'b1);
        step();
        check("fl2_full", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h5, 3'b000, 1'b1, 3'd0, 5'd5, 1'b1);
        step();
        flush = 1'b0;
        idle();
        check("fl2_valid", {31'b0, out_valid}, 32'd0);
        check("fl2_ready", {31'b0, in_ready}, 32'd1);
        check("fl2_cnt", {24'b0, err_cnt}, 32'd1);

        // asynchronous reset mid-stream at occupancy 2
        drive(1'b1, 32'h6, 3'b000, 1'b0, 3'd0, 5'd6, 1'b1);
        step();
        drive(1'b1, 32'h7, 3'b000, 1'b1, 3'd0, 5'd7, 1'b1);
        step();
        idle();
        check("ar_full", {31'b0, in_ready}, 32'd0);
        check("ar_cnt_before", {24'b0, err_cnt}, 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_valid", {31'b0, out_valid}, 32'd0);
        check("ar_cnt", {24'b0, err_cnt}, 32'd0);
        check("ar_ready", {31'b0, in_ready}, 32'd1);
        check("ar_ans", out_ans, 32'd0);
        #3;
        rstn = 1'b1;
        step();
        check("ar_stays_empty", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the ALU.
- Captures the ALU's answer, compare flags and error signal, together with the destination-register tag, through a valid/ready handshake.
- Resolves branch-taken from the compare flags and buffers results in a 2-entry skid buffer, so the ALU side never sees combinational back-pressure from the consumer.
- Counts ALU error events.

Parameters:
WIDTH, 32, data width of ALU answer and buffered result
RD_BITS, 5, width of destination register tag
ERR_CNT_BITS, 8, width of saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  upstream offers an ALU result this cycle
in_ready  output  1  stage can accept; driven from registered occupancy only
in_ans  input  WIDTH  ALU answer
in_flag  input  3  ALU compare flags: [0] equal, [1] signed less-than, [2] unsigned less-than
in_error  input  1  ALU illegal-mode error
in_br_type  input  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved
in_rd  input  RD_BITS  destination register tag
in_we  input  1  result is to be written back
flush  input  1  synchronous discard of all buffered entries
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_ans  output  WIDTH  head answer
out_rd  output  RD_BITS  head tag
out_we  output  1  head write enable (after error and guard masking)
out_br_taken  output  1  head branch-taken
out_error  output  1  head entry carried an ALU error
err_cnt  output  ERR_CNT_BITS  saturating count of accepted error entries

Behaviour:
- Reset (rstn low, asynchronous):
  - Occupancy 0, out_valid 0, in_ready 1.
  - out_ans, out_rd, out_we, out_br_taken, out_error all 0.
  - err_cnt 0.
  - Buffered entry contents also cleared.
- Push: in_valid & in_ready at the edge. Pop: out_valid & out_ready at the edge.
- Storage is a 2-entry FIFO. Occupancy is 0, 1 or 2.
- in_ready = (occupancy != 2), computed from registered state only.
- out_valid = (occupancy != 0). Outputs always show the oldest entry; order is preserved.
- Latency: an entry pushed at edge N is visible on out_* after edge N when the buffer was empty.
- Simultaneous push and pop:
  - At occupancy 1: occupancy stays 1, and the head advances to the new entry.
  - At occupancy 2: no push is possible; a pop brings occupancy to 1.
- Pop at occupancy 0 cannot occur because out_valid is 0.
- Branch resolution is computed at push time from in_flag and in_br_type, and stored with the entry:
  - BEQ = eq; BNE = !eq.
  - BLT = lt; BGE = !lt.
  - BLTU = ltu; BGEU = !ltu.
  - none and reserved = 0.
- Error entry (in_error = 1 at push):
  - Stored with we = 0, br_taken = 0 and error = 1.
  - ans is stored unmodified.
  - err_cnt increments by 1 and saturates at all-ones; it never wraps.
- flush = 1 at an edge:
  - Occupancy becomes 0 and any same-cycle push is dropped, including its err_cnt increment.
  - A same-cycle pop is irrelevant.
  - in_ready returns to 1 on the next cycle.
  - err_cnt is not cleared by flush.
- Reset mid-operation: all entries are lost immediately and outputs go to their reset values without waiting for a clock edge.
- Output data is unspecified when out_valid = 0, except after reset, when it is 0.

Optional Feature:
- Macro: RESULT_STAGE_X0_GUARD_EN.
- Defined: an entry pushed with in_rd == 0 is stored with we = 0, giving a hardwired-zero register guard.
- Undefined: in_we passes through unchanged except for the error masking above.
- br_taken and err_cnt are unaffected either way.

Test Plan:
- Reset then single push: in_ans=0x0000_0005, rd=3, we=1, br_type=0, out_ready=1 -> next cycle out_valid=1, out_ans=5, out_rd=3, out_we=1, out_br_taken=0; one cycle later out_valid=0.
- Back-pressure: out_ready=0, push 0xA, then 0xB -> in_ready=0 after second edge, third offer 0xC held. Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order with no loss or duplication.
- Branch decode with flags: flag=3'b001, type BEQ -> taken 1. flag=3'b100, type BGEU -> taken 0. flag=3'b010, type BGE -> taken 0. flag=3'b000, type 7 -> taken 0.
- Error path: push in_error=1, we=1, rd=4, ans=0 -> out_we=0, out_error=1, err_cnt=1. Push 300 error entries -> err_cnt=255.
- Flush with push: occupancy 2, assert flush with in_valid=1 and in_error=1 -> next cycle out_valid=0, in_ready=1, err_cnt unchanged.
- Reset mid-stream: occupancy 2, drop rstn between edges -> out_valid=0 and err_cnt=0 immediately. With RESULT_STAGE_X0_GUARD_EN defined, push rd=0, we=1 -> out_we=0.
